// File: rtl/mcu_pkg.sv
// mcu_pkg
// Shared definitions for the MCU control path.
// - Stage encoding used by the stage sequencer and the control decoder.
// - Default program-memory address width and instruction word width.
// - Internal sequencer FSM states and the helper that maps them onto the
//   externally visible 2-bit stage code.
package mcu_pkg;

  localparam int MCU_ADDR_W  = 8;
  localparam int MCU_INSTR_W = 12;

  // Externally visible stage code consumed by the control decoder.
  typedef enum logic [1:0] {
    STAGE_LOAD    = 2'b00,
    STAGE_FETCH   = 2'b01,
    STAGE_DECODE  = 2'b10,
    STAGE_EXECUTE = 2'b11
  } stage_e;

  // Sequencer FSM. The three LOAD_* states all present as STAGE_LOAD so
  // program memory keeps writing until the last word has landed.
  typedef enum logic [2:0] {
    SEQ_LOAD       = 3'd0,
    SEQ_LOAD_FLUSH = 3'd1,
    SEQ_LOAD_WAIT  = 3'd2,
    SEQ_FETCH      = 3'd3,
    SEQ_DECODE     = 3'd4,
    SEQ_EXECUTE    = 3'd5
  } seq_state_e;

  function automatic stage_e stage_of(input seq_state_e s);
    stage_e st;
    case (s)
      SEQ_FETCH:   st = STAGE_FETCH;
      SEQ_DECODE:  st = STAGE_DECODE;
      SEQ_EXECUTE: st = STAGE_EXECUTE;
      default:     st = STAGE_LOAD;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mcu_stage_sequencer.sv
// mcu_stage_sequencer
// Producer side of the MCU control path. Accepts a host stream of
// instruction words during LOAD and presents them (registered) as program
// memory write address/data, then cycles FETCH -> DECODE -> EXECUTE.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   host word handshake; in_data word, in_last marks end
//   run_en              1 = execute, 0 = pause at FETCH
//   reload              return to LOAD; honoured only in FETCH
//   stage               LOAD=00, FETCH=01, DECODE=10, EXECUTE=11
//   load_addr/instr     program-memory write address/data (registered)
//   load_count          words accepted so far
//   loaded              program load complete
//   load_full           sticky: depth reached without in_last
//   retired             EXECUTE cycles since last load, wraps
module mcu_stage_sequencer
  import mcu_pkg::*;
#(
  parameter int ADDR_W     = MCU_ADDR_W,
  parameter int INSTR_W    = MCU_INSTR_W,
  parameter int PROG_DEPTH = 256,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  input  logic               in_last,
  output logic               in_ready,
  input  logic               run_en,
  input  logic               reload,
  output logic [1:0]         stage,
  output logic [ADDR_W-1:0]  load_addr,
  output logic [INSTR_W-1:0] load_instr,
  output logic [ADDR_W:0]    load_count,
  output logic               loaded,
  output logic               load_full,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(PROG_DEPTH - 1);

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  load_addr_q, load_addr_d;
  logic [INSTR_W-1:0] load_instr_q, load_instr_d;
  logic [ADDR_W:0]    load_count_q, load_count_d;
  logic               loaded_q, loaded_d;
  logic               load_full_q, load_full_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic accept;
  logic at_depth;

  // Ready depends only on registered state, so there is no path from
  // in_valid to in_ready. The flush and wait states are excluded by the
  // state compare itself.
  assign in_ready = (state_q == SEQ_LOAD) && !loaded_q;
  assign accept   = in_valid && in_ready;
  assign at_depth = (load_count_q == LAST_IDX);

  always_comb begin
    state_d      = state_q;
    load_addr_d  = load_addr_q;
    load_instr_d = load_instr_q;
    load_count_d = load_count_q;
    loaded_d     = loaded_q;
    load_full_d  = load_full_q;
    retired_d    = retired_q;

    case (state_q)
      SEQ_LOAD: begin
        if (accept) begin
          load_instr_d = in_data;
          load_addr_d  = load_count_q[ADDR_W-1:0];
          load_count_d = load_count_q + 1'b1;
          // One flush cycle keeps the stage at LOAD so the final word,
          // which only just became visible on load_addr/load_instr, is
          // written before the run loop starts.
          if (in_last || at_depth) begin
            state_d = SEQ_LOAD_FLUSH;
          end
          if (!in_last && at_depth) begin
            load_full_d = 1'b1;
          end
        end
      end

      SEQ_LOAD_FLUSH: begin
        loaded_d = 1'b1;
        state_d  = SEQ_LOAD_WAIT;
      end

      SEQ_LOAD_WAIT: begin
        if (run_en) begin
          state_d = SEQ_FETCH;
        end
      end

      SEQ_FETCH: begin
        // reload wins over run_en; the write port contents are left alone.
        if (reload) begin
          state_d      = SEQ_LOAD;
          loaded_d     = 1'b0;
          load_count_d = '0;
          load_full_d  = 1'b0;
          retired_d    = '0;
        end else if (run_en) begin
          state_d = SEQ_DECODE;
        end
      end

      SEQ_DECODE: begin
        state_d = SEQ_EXECUTE;
      end

      SEQ_EXECUTE: begin
        retired_d = retired_q + 1'b1;
        state_d   = SEQ_FETCH;
      end

      default: begin
        state_d = SEQ_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEQ_LOAD;
      load_addr_q  <= '0;
      load_instr_q <= '0;
      load_count_q <= '0;
      loaded_q     <= 1'b0;
      load_full_q  <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      load_addr_q  <= load_addr_d;
      load_instr_q <= load_instr_d;
      load_count_q <= load_count_d;
      loaded_q     <= loaded_d;
      load_full_q  <= load_full_d;
      retired_q    <= retired_d;
    end
  end

  assign stage      = stage_of(state_q);
  assign load_addr  = load_addr_q;
  assign load_instr = load_instr_q;
  assign load_count = load_count_q;
  assign loaded     = loaded_q;
  assign load_full  = load_full_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mcu_stage_sequencer.sv
// tb_mcu_stage_sequencer
// Self-checking bench for mcu_stage_sequencer. A behavioural model of the
// sequencer's observable rules runs alongside the DUT and every output is
// compared on each falling edge; a small program-memory image is built from
// the DUT write port so loaded programs can be checked word for word.
module tb_mcu_stage_sequencer;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 12;
  localparam int DEPTH   = 256;
  localparam int CNT_W   = 16;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [INSTR_W-1:0] in_data;
  logic               in_last;
  logic               in_ready;
  logic               run_en;
  logic               reload;
  logic [1:0]         stage;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_instr;
  logic [ADDR_W:0]    load_count;
  logic               loaded;
  logic               load_full;
  logic [CNT_W-1:0]   retired;

  int total = 0;
  int bad   = 0;
  logic check_en = 1'b0;

  logic [INSTR_W-1:0] pmem [DEPTH];

  // Model state, expressed in terms of the observable behaviour.
  int m_stage   = 0;
  int m_flush   = 0;
  int m_loaded  = 0;
  int m_full    = 0;
  int m_count   = 0;
  int m_addr    = 0;
  int m_instr   = 0;
  int m_retired = 0;

  mcu_stage_sequencer #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .PROG_DEPTH(DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .run_en    (run_en),
    .reload    (reload),
    .stage     (stage),
    .load_addr (load_addr),
    .load_instr(load_instr),
    .load_count(load_count),
    .loaded    (loaded),
    .load_full (load_full),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic noteTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got=timeout want=event at %0t", name, $time);
  endtask

  function automatic int model_ready();
    return (m_stage == 0 && m_flush == 0 && m_loaded == 0) ? 1 : 0;
  endfunction

  // Model advance: one step per rising edge using the inputs the DUT sees.
  always @(posedge clk) begin
    if (rst) begin
      m_stage = 0; m_flush = 0; m_loaded = 0; m_full = 0;
      m_count = 0; m_addr = 0; m_instr = 0; m_retired = 0;
    end else if (m_stage == 0) begin
      if (m_flush != 0) begin
        m_flush  = 0;
        m_loaded = 1;
      end else if (m_loaded != 0) begin
        if (run_en) m_stage = 1;
      end else if (in_valid) begin
        m_instr = int'(in_data);
        m_addr  = m_count % DEPTH;
        if (in_last || m_count == DEPTH - 1) m_flush = 1;
        if (!in_last && m_count == DEPTH - 1) m_full = 1;
        m_count = m_count + 1;
      end
    end else if (m_stage == 1) begin
      if (reload) begin
        m_stage = 0; m_loaded = 0; m_count = 0; m_full = 0; m_retired = 0;
      end else if (run_en) begin
        m_stage = 2;
      end
    end else if (m_stage == 2) begin
      m_stage = 3;
    end else begin
      m_retired = (m_retired + 1) % (1 << CNT_W);
      m_stage   = 1;
    end
  end

  // Program memory image: written from the DUT port on every LOAD cycle.
  always @(posedge clk) begin
    if (check_en && !rst && stage == 2'b00) pmem[load_addr] <= load_instr;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("stage",      32'(stage),      32'(m_stage));
      checkOutput("in_ready",   32'(in_ready),   32'(model_ready()));
      checkOutput("load_addr",  32'(load_addr),  32'(m_addr));
      checkOutput("load_instr", 32'(load_instr), 32'(m_instr));
      checkOutput("load_count", 32'(load_count), 32'(m_count));
      checkOutput("loaded",     32'(loaded),     32'(m_loaded));
      checkOutput("load_full",  32'(load_full),  32'(m_full));
      checkOutput("retired",    32'(retired),    32'(m_retired));
    end
  end

  // Offer one word from a falling edge and hold it until accepted.
  task automatic sendWord(input logic [INSTR_W-1:0] data, input logic last, input int addr);
    int n;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      noteTimeout("accept_wait");
    end else begin
      @(negedge clk);
      checkOutput("accept_instr", 32'(load_instr), 32'(data));
      checkOutput("accept_addr",  32'(load_addr),  32'(addr));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitStage(input logic [1:0] want, input int limit);
    int n;
    n = 0;
    while (stage != want && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (stage != want) noteTimeout("stage_wait");
  endtask

  task automatic applyStimulus();
    logic [INSTR_W-1:0] w;

    // Reset state.
    checkOutput("rst_stage",  32'(stage), 32'd0);
    checkOutput("rst_count",  32'(load_count), 32'd0);
    checkOutput("rst_ready",  32'(in_ready), 32'd1);
    rst = 1'b0;
    idleCycles(1);

    // Three-word program with gaps; hold in LOAD until run_en.
    $display("[TB] three-word load");
    sendWord(12'h8A1, 1'b0, 0);
    idleCycles(2);
    sendWord(12'h2F0, 1'b0, 1);
    idleCycles(1);
    sendWord(12'h500, 1'b1, 2);
    checkOutput("flush_ready", 32'(in_ready), 32'd0);
    // A fourth word offered after the last one must never be taken.
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    idleCycles(4);
    in_valid = 1'b0;
    checkOutput("p1_loaded", 32'(loaded), 32'd1);
    checkOutput("p1_count",  32'(load_count), 32'd3);
    checkOutput("p1_stage",  32'(stage), 32'd0);
    checkOutput("p1_mem0",   32'(pmem[0]), 32'h8A1);
    checkOutput("p1_mem1",   32'(pmem[1]), 32'h2F0);
    checkOutput("p1_mem2",   32'(pmem[2]), 32'h500);

    // Run four instructions.
    $display("[TB] run loop");
    run_en = 1'b1;
    idleCycles(1);
    checkOutput("run_fetch", 32'(stage), 32'd1);
    idleCycles(12);
    checkOutput("run_retired4", 32'(retired), 32'd4);
    checkOutput("run_stage4",   32'(stage), 32'd1);
    idleCycles(1);
    checkOutput("run_decode", 32'(stage), 32'd2);

    // Drop run_en in DECODE: EXECUTE still happens, then FETCH holds.
    run_en = 1'b0;
    idleCycles(1);
    checkOutput("pause_exec", 32'(stage), 32'd3);
    idleCycles(1);
    checkOutput("pause_fetch", 32'(stage), 32'd1);
    idleCycles(3);
    checkOutput("pause_hold",    32'(stage), 32'd1);
    checkOutput("pause_retired", 32'(retired), 32'd5);
    run_en = 1'b1;
    idleCycles(1);
    checkOutput("resume_decode", 32'(stage), 32'd2);

    // reload in EXECUTE is ignored; in FETCH it returns to LOAD.
    $display("[TB] reload");
    waitStage(2'b11, 6);
    reload = 1'b1;
    run_en = 1'b0;
    idleCycles(1);
    reload = 1'b0;
    checkOutput("reload_ign", 32'(stage), 32'd1);
    idleCycles(1);
    checkOutput("reload_ign2", 32'(stage), 32'd1);
    reload = 1'b1;
    idleCycles(1);
    reload = 1'b0;
    checkOutput("reload_stage",   32'(stage), 32'd0);
    checkOutput("reload_count",   32'(load_count), 32'd0);
    checkOutput("reload_retired", 32'(retired), 32'd0);
    checkOutput("reload_ready",   32'(in_ready), 32'd1);
    sendWord(12'h123, 1'b1, 0);
    idleCycles(2);
    checkOutput("p2_loaded", 32'(loaded), 32'd1);
    checkOutput("p2_mem0",   32'(pmem[0]), 32'h123);

    // Reset in the middle of a partial load.
    $display("[TB] reset mid-load");
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    sendWord(12'hABC, 1'b0, 0);
    sendWord(12'hDEF, 1'b0, 1);
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    checkOutput("mrst_stage", 32'(stage), 32'd0);
    checkOutput("mrst_addr",  32'(load_addr), 32'd0);
    checkOutput("mrst_instr", 32'(load_instr), 32'd0);
    checkOutput("mrst_count", 32'(load_count), 32'd0);
    checkOutput("mrst_ret",   32'(retired), 32'd0);

    // Fill to depth without in_last.
    $display("[TB] depth fill");
    for (int i = 0; i < DEPTH; i++) begin
      w = 12'((i * 37 + 5) ^ 12'h5A5);
      sendWord(w, 1'b0, i);
      if (i % 41 == 0) idleCycles(1);
    end
    idleCycles(2);
    checkOutput("full_flag",   32'(load_full), 32'd1);
    checkOutput("full_loaded", 32'(loaded), 32'd1);
    checkOutput("full_count",  32'(load_count), 32'd256);
    checkOutput("full_addr",   32'(load_addr), 32'd255);
    checkOutput("full_ready",  32'(in_ready), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      w = 12'((i * 37 + 5) ^ 12'h5A5);
      checkOutput("full_mem", 32'(pmem[i]), 32'(w));
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    run_en   = 1'b0;
    reload   = 1'b0;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk);
    applyStimulus();
    idleCycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
